// File: rtl/zero_opt_pkg.sv
// Shared constants and state encoding for the zero-optimised NFU pipeline controller.
package zero_opt_pkg;

  localparam int ZO_D               = 3;
  localparam int ZO_REPL_LOAD_WIDTH = 2;
  localparam int ZO_CNT_WIDTH       = 12;
  localparam int ZO_PIPE_LAT        = 3;
  localparam int ZO_NFU3_LAT        = 2;
  localparam int ZO_SIG_ENTRIES     = 16;
  localparam int ZO_SIG_AW          = 4;

  // Replacement-select code meaning "load no candidate group this cycle".
  localparam int REPL_NOLOAD = ZO_D;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SIG   = 3'd1,
    ST_REPL  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_DRAIN = 3'd4,
    ST_WRITE = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/zero_opt_blk_cnt.sv
// Loadable down-counter with a terminal flag; it saturates at zero instead of wrapping.
module zero_opt_blk_cnt #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         last
);

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/zero_opt_pipe_ctrl.sv
// Sequencer for the zero-optimised NFU pipeline: sigmoid load, candidate loads,
// block issue, pipeline drain and NBout write-back.
module zero_opt_pipe_ctrl
  import zero_opt_pkg::*;
#(
  parameter int D               = ZO_D,
  parameter int REPL_LOAD_WIDTH = ZO_REPL_LOAD_WIDTH,
  parameter int CNT_WIDTH       = ZO_CNT_WIDTH,
  parameter int PIPE_LAT        = ZO_PIPE_LAT,
  parameter int NFU3_LAT        = ZO_NFU3_LAT,
  parameter int SIG_ENTRIES     = ZO_SIG_ENTRIES,
  parameter int SIG_AW          = ZO_SIG_AW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_start,
  input  logic [CNT_WIDTH-1:0]       i_num_in_blk,
  input  logic [CNT_WIDTH-1:0]       i_num_out_blk,
  input  logic                       i_use_partial,
  input  logic                       i_last_pass,
  input  logic                       i_load_sig,
  input  logic                       i_buf_ready,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_sig_load,
  output logic [SIG_AW-1:0]          o_sig_addr,
  output logic                       o_repl_rd,
  output logic [REPL_LOAD_WIDTH-1:0] o_sel_repl_load,
  output logic                       o_in_rd,
  output logic                       o_in_zero,
  output logic                       o_load_nbout,
  output logic                       o_nbout_nfu2_nfu3,
  output logic                       o_nbout_wr
);

  localparam int DRAIN_W = $clog2(PIPE_LAT + NFU3_LAT + 1);

  state_t state_reg, state_next;

  logic [CNT_WIDTH-1:0] num_in_reg;
  logic                 use_partial_reg;
  logic                 last_pass_reg;
  logic                 first_repl_reg;

  logic                       in_load, in_dec, in_last;
  logic [CNT_WIDTH-1:0]       in_load_val, in_count;
  logic                       out_load, out_dec, out_last;
  logic [CNT_WIDTH-1:0]       out_count;
  logic                       repl_load, repl_dec, repl_last;
  logic [REPL_LOAD_WIDTH-1:0] repl_count;
  logic                       drain_load, drain_dec, drain_last;
  logic [DRAIN_W-1:0]         drain_load_val, drain_count;
  logic                       sig_cnt_load, sig_dec, sig_last;
  logic [SIG_AW-1:0]          sig_count;

  logic accept, zero_job, repl_fire, issue_fire;

  assign accept     = (state_reg == ST_IDLE) && i_start;
  assign zero_job   = (i_num_in_blk == '0) || (i_num_out_blk == '0);
  assign repl_fire  = (state_reg == ST_REPL) && i_buf_ready;
  assign issue_fire = (state_reg == ST_ISSUE) && i_buf_ready;

  // Counter controls: the REPL, drain and SIG counters are preloaded whenever their
  // state is not active, so they are full on entry; input/output counts load per job/block.
  always_comb begin
    in_load        = (state_reg == ST_IDLE) || (state_reg == ST_WRITE);
    in_load_val    = (state_reg == ST_IDLE) ? (i_num_in_blk - 1'b1) : (num_in_reg - 1'b1);
    in_dec         = issue_fire;
    out_load       = (state_reg == ST_IDLE);
    out_dec        = (state_reg == ST_WRITE);
    repl_load      = (state_reg != ST_REPL);
    repl_dec       = repl_fire;
    drain_load     = (state_reg != ST_DRAIN);
    drain_load_val = last_pass_reg ? DRAIN_W'(PIPE_LAT + NFU3_LAT - 1) : DRAIN_W'(PIPE_LAT - 1);
    drain_dec      = (state_reg == ST_DRAIN);
    sig_cnt_load   = (state_reg != ST_SIG);
    sig_dec        = (state_reg == ST_SIG);
  end

  zero_opt_blk_cnt #(.W(CNT_WIDTH)) u_in_cnt (
    .clk(clk), .rst_n(rst_n), .load(in_load), .load_val(in_load_val),
    .dec(in_dec), .count(in_count), .last(in_last)
  );

  zero_opt_blk_cnt #(.W(CNT_WIDTH)) u_out_cnt (
    .clk(clk), .rst_n(rst_n), .load(out_load), .load_val(i_num_out_blk - 1'b1),
    .dec(out_dec), .count(out_count), .last(out_last)
  );

  zero_opt_blk_cnt #(.W(REPL_LOAD_WIDTH)) u_repl_cnt (
    .clk(clk), .rst_n(rst_n), .load(repl_load), .load_val(REPL_LOAD_WIDTH'(D - 1)),
    .dec(repl_dec), .count(repl_count), .last(repl_last)
  );

  zero_opt_blk_cnt #(.W(DRAIN_W)) u_drain_cnt (
    .clk(clk), .rst_n(rst_n), .load(drain_load), .load_val(drain_load_val),
    .dec(drain_dec), .count(drain_count), .last(drain_last)
  );

  zero_opt_blk_cnt #(.W(SIG_AW)) u_sig_cnt (
    .clk(clk), .rst_n(rst_n), .load(sig_cnt_load), .load_val(SIG_AW'(SIG_ENTRIES - 1)),
    .dec(sig_dec), .count(sig_count), .last(sig_last)
  );

  // State register, job configuration capture and first-REPL-cycle flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      num_in_reg      <= '0;
      use_partial_reg <= 1'b0;
      last_pass_reg   <= 1'b0;
      first_repl_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        num_in_reg      <= i_num_in_blk;
        use_partial_reg <= i_use_partial;
        last_pass_reg   <= i_last_pass;
      end
      // Entering REPL from anything but ISSUE starts a new output block.
      first_repl_reg <= (state_next == ST_REPL) &&
                        ((state_reg == ST_IDLE) || (state_reg == ST_SIG) || (state_reg == ST_WRITE));
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          if (zero_job)        state_next = ST_DONE;
          else if (i_load_sig) state_next = ST_SIG;
          else                 state_next = ST_REPL;
        end
      end
      ST_SIG:   if (sig_last) state_next = ST_REPL;
      ST_REPL:  if (repl_fire && repl_last) state_next = ST_ISSUE;
      ST_ISSUE: if (issue_fire) state_next = in_last ? ST_DRAIN : ST_REPL;
      ST_DRAIN: if (drain_last) state_next = ST_WRITE;
      ST_WRITE: state_next = out_last ? ST_DONE : ST_REPL;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Datapath controls decoded from the state and the buffer-ready handshake.
  always_comb begin
    o_busy            = (state_reg != ST_IDLE);
    o_done            = (state_reg == ST_DONE);
    o_sig_load        = (state_reg == ST_SIG);
    o_sig_addr        = '0;
    if (state_reg == ST_SIG) o_sig_addr = SIG_AW'(SIG_ENTRIES - 1) - sig_count;
    o_repl_rd         = repl_fire;
    o_sel_repl_load   = repl_fire ? (REPL_LOAD_WIDTH'(D - 1) - repl_count) : REPL_LOAD_WIDTH'(D);
    o_in_rd           = issue_fire;
    o_in_zero         = !issue_fire;
    o_load_nbout      = (state_reg == ST_REPL) && first_repl_reg && use_partial_reg;
    o_nbout_nfu2_nfu3 = ((state_reg == ST_DRAIN) || (state_reg == ST_WRITE)) && !last_pass_reg;
    o_nbout_wr        = (state_reg == ST_WRITE);
  end

endmodule

// File: tb/tb_zero_opt_pipe_ctrl.sv
// Randomised bench for zero_opt_pipe_ctrl against an operation-list reference model.
module tb_zero_opt_pipe_ctrl;
  import zero_opt_pkg::*;

  localparam int K_SIG = 0, K_REPL = 1, K_ISSUE = 2, K_DRAIN = 3, K_WRITE = 4, K_DONE = 5;

  typedef struct packed {
    logic [2:0] kind;
    logic [3:0] arg;
    logic       ld;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [11:0] i_num_in_blk, i_num_out_blk;
  logic        i_use_partial, i_last_pass, i_load_sig, i_buf_ready;
  logic        o_busy, o_done, o_sig_load, o_repl_rd, o_in_rd, o_in_zero;
  logic        o_load_nbout, o_nbout_nfu2_nfu3, o_nbout_wr;
  logic [3:0]  o_sig_addr;
  logic [1:0]  o_sel_repl_load;

  int n_cmp = 0;
  int n_err = 0;

  zero_opt_pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .i_num_in_blk(i_num_in_blk), .i_num_out_blk(i_num_out_blk),
    .i_use_partial(i_use_partial), .i_last_pass(i_last_pass), .i_load_sig(i_load_sig),
    .i_buf_ready(i_buf_ready), .o_busy(o_busy), .o_done(o_done),
    .o_sig_load(o_sig_load), .o_sig_addr(o_sig_addr), .o_repl_rd(o_repl_rd),
    .o_sel_repl_load(o_sel_repl_load), .o_in_rd(o_in_rd), .o_in_zero(o_in_zero),
    .o_load_nbout(o_load_nbout), .o_nbout_nfu2_nfu3(o_nbout_nfu2_nfu3), .o_nbout_wr(o_nbout_wr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Field order: busy done sig_load sig_addr repl_rd sel in_rd in_zero load_nbout nfu2_nfu3 wr
  function automatic logic [14:0] mk(input bit busy, input bit done, input bit sl, input logic [3:0] addr,
                                     input bit rr, input logic [1:0] sel, input bit ird, input bit iz,
                                     input bit ld, input bit nfu, input bit wr);
    return {busy, done, sl, addr, rr, sel, ird, iz, ld, nfu, wr};
  endfunction

  function automatic logic [14:0] obs();
    return {o_busy, o_done, o_sig_load, o_sig_addr, o_repl_rd, o_sel_repl_load,
            o_in_rd, o_in_zero, o_load_nbout, o_nbout_nfu2_nfu3, o_nbout_wr};
  endfunction

  function automatic logic [14:0] idle_vec();
    return mk(0, 0, 0, 4'd0, 0, 2'(ZO_D), 0, 1, 0, 0, 0);
  endfunction

  // mode 0: always ready; 1: random ready; 2: ready low in cycles 2..4 after start.
  task automatic run_job(input int nin, input int nout, input bit up, input bit lp, input bit ls,
                         input int mode, input bit abort_drain);
    op_t ops[$];
    op_t h;
    op_t o;
    int cyc = 0;
    int wr_cnt = 0;
    int done_cyc = 0;
    int exp_cyc;
    bit rdy;
    logic [14:0] ev;
    bit e_sl, e_rr, e_ird, e_ld, e_nfu, e_wr, e_done;
    logic [3:0] e_addr;
    logic [1:0] e_sel;

    // Expected job as a flat list of operations in issue order.
    if (nin == 0 || nout == 0) begin
      o = '{kind: 3'(K_DONE), arg: 4'd0, ld: 1'b0}; ops.push_back(o);
    end else begin
      if (ls) for (int a = 0; a < ZO_SIG_ENTRIES; a++) begin
        o = '{kind: 3'(K_SIG), arg: 4'(a), ld: 1'b0}; ops.push_back(o);
      end
      for (int ob = 0; ob < nout; ob++) begin
        for (int ib = 0; ib < nin; ib++) begin
          for (int r = 0; r < ZO_D; r++) begin
            o = '{kind: 3'(K_REPL), arg: 4'(r), ld: (ib == 0 && r == 0)}; ops.push_back(o);
          end
          o = '{kind: 3'(K_ISSUE), arg: 4'd0, ld: 1'b0}; ops.push_back(o);
        end
        for (int d = 0; d < ZO_PIPE_LAT + (lp ? ZO_NFU3_LAT : 0); d++) begin
          o = '{kind: 3'(K_DRAIN), arg: 4'd0, ld: 1'b0}; ops.push_back(o);
        end
        o = '{kind: 3'(K_WRITE), arg: 4'd0, ld: 1'b0}; ops.push_back(o);
      end
      o = '{kind: 3'(K_DONE), arg: 4'd0, ld: 1'b0}; ops.push_back(o);
    end

    @(negedge clk);
    i_num_in_blk = 12'(nin); i_num_out_blk = 12'(nout);
    i_use_partial = up; i_last_pass = lp; i_load_sig = ls;
    i_start = 1'b1; i_buf_ready = 1'b1;
    #1 check_val("idle_at_start", 32'(obs()), 32'(idle_vec()));

    while (ops.size() > 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = !(cyc >= 2 && cyc <= 4);
      endcase
      i_buf_ready = rdy;
      // Scramble start and configuration while busy; none of it may have an effect.
      i_start = ($urandom_range(0, 3) == 0);
      i_num_in_blk = 12'($urandom); i_num_out_blk = 12'($urandom);
      i_use_partial = 1'($urandom); i_last_pass = 1'($urandom); i_load_sig = 1'($urandom);
      #1;
      h = ops[0];
      if (abort_drain && h.kind == 3'(K_DRAIN)) begin
        i_start = 1'b0;
        rst_n = 1'b0;
        #1 check_val("reset_mid_drain", 32'(obs()), 32'(idle_vec()));
        @(negedge clk);
        rst_n = 1'b1;
        ops.delete();
        return;
      end
      e_sl = 0; e_addr = 4'd0; e_rr = 0; e_sel = 2'(ZO_D); e_ird = 0;
      e_ld = 0; e_nfu = 0; e_wr = 0; e_done = 0;
      case (int'(h.kind))
        K_SIG: begin e_sl = 1; e_addr = h.arg; void'(ops.pop_front()); end
        K_REPL: begin
          e_ld = h.ld && up;
          if (rdy) begin e_rr = 1; e_sel = h.arg[1:0]; void'(ops.pop_front()); end
          else begin h.ld = 1'b0; ops[0] = h; end
        end
        K_ISSUE: if (rdy) begin e_ird = 1; void'(ops.pop_front()); end
        K_DRAIN: begin e_nfu = !lp; void'(ops.pop_front()); end
        K_WRITE: begin e_nfu = !lp; e_wr = 1; void'(ops.pop_front()); end
        default: begin e_done = 1; void'(ops.pop_front()); end
      endcase
      ev = mk(1, e_done, e_sl, e_addr, e_rr, e_sel, e_ird, !e_ird, e_ld, e_nfu, e_wr);
      check_val($sformatf("cyc%0d", cyc), 32'(obs()), 32'(ev));
      if (o_nbout_wr) wr_cnt++;
      if (o_done && done_cyc == 0) done_cyc = cyc;
    end
    if (ops.size() != 0) check_val("timeout", 32'(ops.size()), 32'd0);

    @(negedge clk);
    i_start = 1'b0;
    #1 check_val("idle_after_done", 32'(obs()), 32'(idle_vec()));
    check_val("write_count", 32'(wr_cnt), (nin == 0 || nout == 0) ? 32'd0 : 32'(nout));
    if (mode != 1) begin
      if (nin == 0 || nout == 0) exp_cyc = 1;
      else exp_cyc = (ls ? ZO_SIG_ENTRIES : 0)
                   + nout * (nin * (ZO_D + 1) + ZO_PIPE_LAT + (lp ? ZO_NFU3_LAT : 0) + 1) + 1
                   + ((mode == 2) ? 3 : 0);
      check_val("done_cycle", 32'(done_cyc), 32'(exp_cyc));
    end
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_num_in_blk = '0; i_num_out_blk = '0;
    i_use_partial = 1'b0; i_last_pass = 1'b0; i_load_sig = 1'b0; i_buf_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_val("reset_state", 32'(obs()), 32'(idle_vec()));
    @(negedge clk);
    rst_n = 1'b1;

    run_job(2, 1, 1, 0, 0, 0, 0);   // write at cycle 12, done at 13
    run_job(1, 2, 1, 1, 1, 0, 0);   // sigmoid load plus two final writes
    run_job(2, 1, 1, 0, 0, 2, 0);   // three-cycle stall in REPL index 1
    run_job(0, 3, 1, 0, 0, 0, 0);   // empty job
    run_job(3, 0, 0, 1, 1, 0, 0);   // empty job
    run_job(2, 2, 1, 1, 0, 1, 1);   // reset lands in DRAIN
    run_job(2, 2, 0, 1, 0, 0, 0);   // clean job after the reset

    for (int j = 0; j < 20; j++) begin
      run_job($urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
              1'($urandom), $urandom_range(0, 1), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
